// File: rtl/butterfly_dif_if.sv
// butterfly_dif_if
//   Operand/result bundle for the DIF radix-2 butterfly.
//   Handshake: a transfer happens on a rising clk edge where val and rdy are
//   both high. The producer holds val and its data stable until that edge.
//   The consumer may change rdy at any time, and rdy has no effect while val
//   is low.
//   recv side : recv_val, recv_rdy, ar/ac (a), br/bc (b), wr/wc (twiddle)
//   send side : send_val, send_rdy, cr/cc (c = a+b), dr/dc (d = (a-b)*w)
//   modport slave  : the butterfly's view
//   modport master : the environment's view
interface butterfly_dif_if #(
  parameter int n = 32
);
  logic         recv_val;
  logic         recv_rdy;
  logic [n-1:0] ar;
  logic [n-1:0] ac;
  logic [n-1:0] br;
  logic [n-1:0] bc;
  logic [n-1:0] wr;
  logic [n-1:0] wc;
  logic         send_val;
  logic         send_rdy;
  logic [n-1:0] cr;
  logic [n-1:0] cc;
  logic [n-1:0] dr;
  logic [n-1:0] dc;

  modport slave (
    input  recv_val, ar, ac, br, bc, wr, wc, send_rdy,
    output recv_rdy, send_val, cr, cc, dr, dc
  );

  modport master (
    output recv_val, ar, ac, br, bc, wr, wc, send_rdy,
    input  recv_rdy, send_val, cr, cc, dr, dc
  );
endinterface

// File: rtl/butterfly_dif.sv
// butterfly_dif
//   Gentleman-Sande (decimation-in-frequency) radix-2 butterfly on signed
//   Q(n-d).d complex operands:
//     c = a + b
//     d = (a - b) * w
//   The block uses one time-shared n x n real multiplier. It always takes
//   four multiply cycles after the accept edge. All outputs are registered.
//   Ports:
//     clk       clock
//     reset     synchronous, active-high. Discards any in-flight operation.
//     bus       butterfly_dif_if.slave, which carries the operand and result
//               handshakes
//     dbg_state current FSM state: 0 = IDLE, 1 = CALC, 2 = DONE
module butterfly_dif #(
  parameter int n = 32,
  parameter int d = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  butterfly_dif_if.slave        bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic recv_rdy_q, send_val_q;
  logic recv_rdy_nxt, send_val_nxt;
  logic accept;

  logic [1:0]   step;
  logic [n-1:0] cr_q, cc_q, dr_q, dc_q;
  logic [n-1:0] er, ec, wr_q, wc_q;
  logic [n-1:0] acc_r, acc_i;

  logic signed [n-1:0]   mx, my;
  logic signed [2*n-1:0] prod;
  logic [n-1:0]          p;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.recv_val)  state_nxt = CALC;
      CALC: if (step == 2'd3)  state_nxt = DONE;
      DONE: if (bus.send_rdy)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Output decode. The handshake flags are registered copies of the flags
  // for the state being entered, so they line up with the state register.
  always_comb begin
    accept       = (state == IDLE) && bus.recv_val;
    recv_rdy_nxt = (state_nxt == IDLE);
    send_val_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      recv_rdy_q <= 1'b1;
      send_val_q <= 1'b0;
    end else begin
      recv_rdy_q <= recv_rdy_nxt;
      send_val_q <= send_val_nxt;
    end
  end

  // Operand select for the shared multiplier:
  //   step 0: er*wr   step 1: ec*wc   step 2: er*wc   step 3: ec*wr
  always_comb begin
    mx   = step[0] ? $signed(ec) : $signed(er);
    my   = (step == 2'd0 || step == 2'd3) ? $signed(wr_q) : $signed(wc_q);
    prod = mx * my;
    // Arithmetic shift floors toward -inf. Keep the low n bits (wrap).
    p    = n'(prod >>> d);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      cr_q  <= '0;
      cc_q  <= '0;
      dr_q  <= '0;
      dc_q  <= '0;
      er    <= '0;
      ec    <= '0;
      wr_q  <= '0;
      wc_q  <= '0;
      acc_r <= '0;
      acc_i <= '0;
      step  <= 2'd0;
    end else if (accept) begin
      cr_q  <= bus.ar + bus.br;
      cc_q  <= bus.ac + bus.bc;
      er    <= bus.ar - bus.br;
      ec    <= bus.ac - bus.bc;
      wr_q  <= bus.wr;
      wc_q  <= bus.wc;
      acc_r <= '0;
      acc_i <= '0;
      step  <= 2'd0;
    end else if (state == CALC) begin
      step <= step + 2'd1;
      case (step)
        2'd0: acc_r <= acc_r + p;
        2'd1: acc_r <= acc_r - p;
        2'd2: acc_i <= acc_i + p;
        default: begin
          // Final product: publish d directly from the accumulators.
          acc_i <= acc_i + p;
          dr_q  <= acc_r;
          dc_q  <= acc_i + p;
        end
      endcase
    end
  end

  assign bus.recv_rdy = recv_rdy_q;
  assign bus.send_val = send_val_q;
  assign bus.cr       = cr_q;
  assign bus.cc       = cc_q;
  assign bus.dr       = dr_q;
  assign bus.dc       = dc_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_butterfly_dif.sv
// tb_butterfly_dif
//   Bench for butterfly_dif with n=32 and d=16. Each scenario task drives
//   stimulus and compares the DUT against a complex-arithmetic reference model.
module tb_butterfly_dif;
  localparam int N = 32;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  butterfly_dif_if #(.n(N)) bus ();

  butterfly_dif #(.n(N), .d(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [4*N-1:0] exp_q[$];

  // Reference model: c = a + b and d = (a - b) * w on Q16.16 complex values.
  // Each real product is floor-scaled by 2^D, and the result wraps mod 2^N.
  function automatic logic [4*N-1:0] model(input logic [N-1:0] a_r, a_i, b_r, b_i,
                                           w_r, w_i);
    logic [N-1:0] e_r, e_i, c_r, c_i, re, im;
    longint t_rr, t_ii, t_ri, t_ir;
    e_r  = a_r - b_r;
    e_i  = a_i - b_i;
    c_r  = a_r + b_r;
    c_i  = a_i + b_i;
    t_rr = (longint'($signed(e_r)) * longint'($signed(w_r))) >>> D;
    t_ii = (longint'($signed(e_i)) * longint'($signed(w_i))) >>> D;
    t_ri = (longint'($signed(e_r)) * longint'($signed(w_i))) >>> D;
    t_ir = (longint'($signed(e_i)) * longint'($signed(w_r))) >>> D;
    re   = N'(t_rr - t_ii);
    im   = N'(t_ri + t_ir);
    return {c_r, c_i, re, im};
  endfunction

  function automatic logic [4*N-1:0] outs();
    return {bus.cr, bus.cc, bus.dr, bus.dc};
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic accept_op(input logic [N-1:0] a_r, a_i, b_r, b_i, w_r, w_i,
                           output bit timeout);
    int k;
    k = 0;
    timeout = 1'b0;
    while (!bus.recv_rdy && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.recv_rdy) begin
      timeout = 1'b1;
      return;
    end
    bus.ar       = a_r;
    bus.ac       = a_i;
    bus.br       = b_r;
    bus.bc       = b_i;
    bus.wr       = w_r;
    bus.wc       = w_i;
    bus.recv_val = 1'b1;
    bus.send_rdy = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    bus.recv_val = 1'b0;
    // The operands must be ignored after the accept edge.
    bus.ar = $urandom; bus.ac = $urandom; bus.br = $urandom;
    bus.bc = $urandom; bus.wr = $urandom; bus.wc = $urandom;
  endtask

  task automatic wait_result(output int lat, output bit timeout);
    lat = 0;
    while (!bus.send_val && lat < 20) begin
      bus.send_rdy = 1'($urandom_range(0, 1));
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    bus.send_rdy = 1'b0;
    timeout = !bus.send_val;
  endtask

  task automatic release_result(input int stall);
    repeat (stall) @(negedge clk);
    bus.send_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.send_rdy = 1'b0;
  endtask

  task automatic run_op(input logic [N-1:0] a_r, a_i, b_r, b_i, w_r, w_i,
                        input int stall, output logic [4*N-1:0] got,
                        output int lat, output bit timeout);
    bit t0, t1;
    accept_op(a_r, a_i, b_r, b_i, w_r, w_i, t0);
    lat = 0;
    t1  = 1'b0;
    if (!t0) wait_result(lat, t1);
    got = outs();
    timeout = t0 | t1;
    if (!timeout) release_result(stall);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset        = 1'b1;
    bus.recv_val = 1'b0;
    bus.send_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (bus.recv_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_recv_rdy got=%b exp=1", bus.recv_rdy);
    end
    n_checks++;
    if (bus.send_val !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_send_val got=%b exp=0", bus.send_val);
    end
    n_checks++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", outs());
    end
  endtask

  task automatic test_directed();
    logic [4*N-1:0] got, exp;
    int lat;
    bit to;
    exp = {32'h0004_0000, 32'h0000_0000, 32'h0000_0000, 32'h0002_0000};
    run_op(32'h0003_0000, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000,
           32'h0000_8000, 32'h0000_8000, 2, got, lat, to);
    n_checks++;
    if (to !== 1'b0) begin
      n_fail++;
      $display("FAIL directed_timeout got=%b exp=0", to);
    end
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL directed_latency got=%0d exp=4", lat);
    end
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL directed_result got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_identity_twiddle();
    logic [N-1:0] a_r, a_i, b_r, b_i;
    logic [4*N-1:0] got, exp;
    int lat;
    bit to;
    for (int i = 0; i < 1000; i++) begin
      a_r = $urandom; a_i = $urandom; b_r = $urandom; b_i = $urandom;
      exp = {a_r + b_r, a_i + b_i, a_r - b_r, a_i - b_i};
      run_op(a_r, a_i, b_r, b_i, 32'h0001_0000, 32'h0, $urandom_range(0, 3),
             got, lat, to);
      n_checks++;
      if (to || lat !== 4) begin
        n_fail++;
        $display("FAIL identity_latency[%0d] got=%0d timeout=%b exp=4", i, lat, to);
      end
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL identity_result[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_random_twiddle();
    logic [N-1:0] a_r, a_i, b_r, b_i, w_r, w_i;
    logic [4*N-1:0] got, exp;
    int lat;
    bit to;
    for (int i = 0; i < 200; i++) begin
      a_r = $urandom; a_i = $urandom; b_r = $urandom; b_i = $urandom;
      w_r = $urandom; w_i = $urandom;
      exp_q.push_back(model(a_r, a_i, b_r, b_i, w_r, w_i));
      run_op(a_r, a_i, b_r, b_i, w_r, w_i, $urandom_range(0, 4), got, lat, to);
      exp = exp_q.pop_front();
      n_checks++;
      if (to || got !== exp) begin
        n_fail++;
        $display("FAIL random_result[%0d] got=%h exp=%h timeout=%b", i, got, exp, to);
      end
    end
  endtask

  task automatic test_rounding();
    logic [4*N-1:0] got, exp;
    int lat;
    bit to;
    exp = {32'h0000_0001, 32'h0, 32'hFFFF_FFFF, 32'h0};
    run_op(32'h0, 32'h0, 32'h1, 32'h0, 32'h0000_8000, 32'h0, 0, got, lat, to);
    n_checks++;
    if (to || got !== exp) begin
      n_fail++;
      $display("FAIL rounding got=%h exp=%h timeout=%b", got, exp, to);
    end
  endtask

  task automatic test_overflow();
    logic [4*N-1:0] got, exp;
    int lat;
    bit to;
    exp = model(32'h7FFF_0000, 32'h8000_0000, 32'h0001_0000, 32'h7FFF_FFFF,
                32'h0001_8000, 32'h0000_4000);
    run_op(32'h7FFF_0000, 32'h8000_0000, 32'h0001_0000, 32'h7FFF_FFFF,
           32'h0001_8000, 32'h0000_4000, 1, got, lat, to);
    n_checks++;
    if (got[4*N-1 -: N] !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL overflow_cr got=%h exp=80000000", got[4*N-1 -: N]);
    end
    n_checks++;
    if (to || got !== exp) begin
      n_fail++;
      $display("FAIL overflow_result got=%h exp=%h timeout=%b", got, exp, to);
    end
  endtask

  task automatic test_backpressure();
    logic [4*N-1:0] got, exp, snap;
    int lat;
    bit to0, to1;
    exp = model(32'h0012_3456, 32'hFFF0_1000, 32'h0003_0000, 32'h0000_8000,
                32'h0000_B505, 32'hFFFF_4AFB);
    accept_op(32'h0012_3456, 32'hFFF0_1000, 32'h0003_0000, 32'h0000_8000,
              32'h0000_B505, 32'hFFFF_4AFB, to0);
    to1 = 1'b0;
    if (!to0) wait_result(lat, to1);
    snap = outs();
    n_checks++;
    if (to0 || to1 || snap !== exp) begin
      n_fail++;
      $display("FAIL bp_result got=%h exp=%h", snap, exp);
    end
    for (int i = 0; i < 10; i++) begin
      bus.recv_val = (i == 4);
      bus.ar = $urandom; bus.br = $urandom; bus.wr = $urandom;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.send_val !== 1'b1 || bus.recv_rdy !== 1'b0 || outs() !== exp) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got val=%b rdy=%b out=%h exp val=1 rdy=0 out=%h",
                 i, bus.send_val, bus.recv_rdy, outs(), exp);
      end
    end
    bus.recv_val = 1'b0;
    bus.send_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.send_rdy = 1'b0;
    n_checks++;
    if (bus.recv_rdy !== 1'b1 || bus.send_val !== 1'b0 || outs() !== exp) begin
      n_fail++;
      $display("FAIL bp_release got rdy=%b val=%b out=%h exp rdy=1 val=0 out=%h",
               bus.recv_rdy, bus.send_val, outs(), exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [4*N-1:0] got, exp;
    int lat;
    bit to;
    accept_op(32'h0005_0000, 32'h0002_0000, 32'h0001_0000, 32'h0007_0000,
              32'h0000_C000, 32'h0000_2000, to);
    @(posedge clk);  // E1
    @(posedge clk);  // E2
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (to || bus.recv_rdy !== 1'b1 || bus.send_val !== 1'b0 || outs() !== '0) begin
      n_fail++;
      $display("FAIL mid_reset got rdy=%b val=%b out=%h exp rdy=1 val=0 out=0",
               bus.recv_rdy, bus.send_val, outs());
    end
    exp = model(32'hFFFE_8000, 32'h0010_0000, 32'h0003_4000, 32'hFFFF_0001,
                32'h0000_E000, 32'hFFFF_9000);
    run_op(32'hFFFE_8000, 32'h0010_0000, 32'h0003_4000, 32'hFFFF_0001,
           32'h0000_E000, 32'hFFFF_9000, 0, got, lat, to);
    n_checks++;
    if (to || lat !== 4 || got !== exp) begin
      n_fail++;
      $display("FAIL post_reset got=%h lat=%0d exp=%h lat=4", got, lat, exp);
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.recv_val = 1'b0;
    bus.send_rdy = 1'b0;
    bus.ar = '0; bus.ac = '0; bus.br = '0; bus.bc = '0; bus.wr = '0; bus.wc = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_rounding();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_identity_twiddle();
    test_random_twiddle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/butterfly_dif.md
Name: butterfly_dif

Overview:
- Decimation-in-frequency (Gentleman-Sande) radix-2 butterfly; the inverse-direction counterpart of the team's decimation-in-time butterfly.
- Computes c = a + b and d = (a - b) * w on signed fixed-point complex operands.
- Used in DIF FFT and inverse-FFT stages.
- val/rdy on both sides; one time-shared real multiplier; fixed 4-cycle multiply sequence.

Parameters:
n, 32, total word width of every real/imag component (signed two's complement)
d, 16, fractional bits (Q(n-d).d format)

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
recv_val  input  1  input operands valid
recv_rdy  output  1  block can accept operands
ar  input  n  a real
ac  input  n  a imag
br  input  n  b real
bc  input  n  b imag
wr  input  n  twiddle real
wc  input  n  twiddle imag
send_val  output  1  results valid
send_rdy  input  1  consumer accepts results
cr  output  n  c real = ar + br
cc  output  n  c imag = ac + bc
dr  output  n  d real = Re((a-b)*w)
dc  output  n  d imag = Im((a-b)*w)

Behaviour:
- Reset, synchronous, active-high; clock clk. Reset dominates all other events, including mid-operation.
- After reset: state IDLE, recv_rdy=1, send_val=0, cr=cc=dr=dc=0, step counter=0. Any in-flight operation is discarded.
- All outputs are registered.
- FSM states are IDLE, CALC, DONE.
- IDLE:
  - recv_rdy=1.
  - On an edge with recv_val=1, the block accepts the operands (edge E0):
    - cr<=ar+br and cc<=ac+bc, mod 2^n, wrap with no saturation.
    - Internal er<=ar-br and ec<=ac-bc, mod 2^n.
    - wr and wc are latched.
    - Accumulators are cleared, step=0, state->CALC, recv_rdy<=0.
  - Inputs are sampled only at E0; later input changes are ignored.
- CALC: one signed n x n -> 2n product per edge, E1..E4.
  - step0: er*wr
  - step1: ec*wc
  - step2: er*wc
  - step3: ec*wr
  - Each product is arithmetically shifted right by d (floor toward -inf) and truncated to the low n bits.
  - Accumulation: real = p0 - p1; imag = p2 + p3. All arithmetic is mod 2^n.
  - At E4: dr/dc <= final accumulators, send_val<=1, state->DONE.
- Latency: send_val is high after the 4th edge following the accept edge.
- DONE:
  - send_val=1; recv_rdy=0.
  - cr/cc/dr/dc hold stable while send_rdy=0 (back-pressure for unlimited cycles).
  - On an edge with send_rdy=1: send_val<=0, recv_rdy<=1, state->IDLE. Outputs keep their last values.
  - No accept is possible in the same cycle as the send; throughput is 1 result per 6 cycles minimum.
- recv_val while not IDLE has no effect.
- send_rdy outside DONE has no effect.

Test Plan:
- n=32, d=16. a=(0x00030000,0x00010000), b=(0x00010000,0xFFFF0000), w=(0x00008000,0x00008000). Required: cr=0x00040000, cc=0, dr=0, dc=0x00020000. send_val rises exactly 4 edges after accept.
- Twiddle w=(0x00010000,0), random a, b. Required: d == a-b exactly; c == a+b. Run 1000 randomized transactions against a golden model with random send_rdy back-pressure.
- Rounding: a=(0,0), b=(1,0), w=(0x00008000,0). er=-1, product -0x8000>>>16 = -1. Required: dr=0xFFFFFFFF, dc=0.
- Overflow wrap: ar=0x7FFF0000, br=0x00010000. Required: cr=0x80000000, dr=0x7FFE0000*wr-scaled with wrap, matching the golden model.
- Back-pressure: hold send_rdy=0 for 10 cycles in DONE. Required: outputs and send_val are stable, recv_rdy=0, and a recv_val pulse is ignored. Then send_rdy=1 for one cycle: recv_rdy=1 on the next cycle.
- Reset mid-CALC (after E2). Required on the next cycle: recv_rdy=1, send_val=0, all outputs 0. A following transaction computes correctly.
